id_operand_stage: RTL and testbench
===================================

# id_operand_stage

Parametrised operand-select and forwarding stage at the ID/EX boundary. Selects ALU operand A from {rs1, PC, zero} and operand B from {rs2, imm, 4}. Resolves rs1/rs2 against NUM_FWD younger in-flight results with priority forwarding, and detects load-use hazards. Registers the result into the ID/EX pipeline register under a valid/ready handshake with flush and a stall counter.

## Interface
- XLEN, 32, datapath width.
- NUM_FWD, 2, forwarding sources; index 0 is the youngest (EX/MEM), higher indices are older (MEM/WB, ...); range 1..4.
- CNT_W, 16, stall-counter width.
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  upstream ID holds a decoded instruction.
- in_ready  out  1  stage accepts this cycle.
- pc_in  in  XLEN  instruction PC.
- imm  in  XLEN  decoded immediate.
- rs1_addr, rs2_addr  in  5 each  source register indices.
- rf_rdata1, rf_rdata2  in  XLEN each  register-file read data.
- src_a  in  2  operand-A select, cpu_types_pkg encoding: SRC_RS1=0, SRC_PC=1, SRC_ZERO=2.
- src_b  in  2  operand-B select: SRC_RS2=0, SRC_IMM=1, SRC_4=2.
- uses_rs2  in  1  rs2 value needed independent of src_b (stores, branches).
- fwd_valid  in  NUM_FWD  entry i writes a register.
- fwd_pending  in  NUM_FWD  entry i result not yet available (load in flight).
- fwd_rd  in  5*NUM_FWD  destination of entry i, packed, entry i at [5i+4:5i].
- fwd_data  in  XLEN*NUM_FWD  result of entry i, packed.
- flush  in  1  kill the held and the incoming instruction.
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_ready  in  1  EX accepts.
- op_a, op_b  out  XLEN each  registered operands.
- rs2_val  out  XLEN  registered forwarded rs2 value (store data / branch compare).
- pc_out  out  XLEN  registered PC.
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles.

## Operation
- Forwarding, per source r in {rs1, rs2}: candidates are entries with fwd_valid[i]=1, fwd_rd[i]==r_addr, and r_addr!=0. The lowest-index candidate wins. With no candidate, the stage uses rf_rdata. x0 always reads 0, whatever rf_rdata shows.
- Hazard: rs1 is needed when src_a==SRC_RS1; rs2 is needed when src_b==SRC_RS2 or uses_rs2=1. hazard=1 when a needed source's winning candidate has fwd_pending=1.
  - A pending older entry shadowed by a non-pending younger match does not stall.
- Operand A = fwd_rs1 / pc_in / 0 per src_a. Operand B = fwd_rs2 / imm / 4 per src_b. Reserved select value 3 gives 0 on either operand.
- in_ready = !flush && !hazard && (!out_valid || out_ready). Combinational; in_ready does not depend on in_valid.
- Capture: when in_valid && in_ready, op_a, op_b, rs2_val and pc_out load, and out_valid becomes 1.
- Drain: when out_valid && out_ready and no capture, out_valid becomes 0. Data registers hold their last value.
- Flush has priority over everything: out_valid becomes 0 next cycle, and no capture happens that cycle.
- Stall counter increments on cycles with in_valid && hazard && !flush. It saturates at 2^CNT_W-1 and never wraps.
- Outputs stay stable while out_valid && !out_ready.

## Timing
- Reset (rst_n=0 at a clk edge) sets out_valid=0, op_a=op_b=rs2_val=pc_out=0 and stall_cnt=0.
  - During reset, in_ready is forced to 0.
  - Reset applied mid-stall discards the held instruction.
- Latency: 1 cycle, input capture edge to out_valid/op_* visible.
- Throughput: 1 instruction/cycle when out_ready=1 and there is no hazard. Capture and drain in the same cycle keep out_valid=1 with the new data.
- Forwarding and hazard logic are combinational on the same-cycle fwd_* inputs. The producer must present the fwd_* values for the cycle the instruction sits at the input.
- A load-use hazard stalls for as many cycles as fwd_pending stays high. Capture happens on the first cycle it drops.
- Simultaneous flush and hazard: flush wins, and stall_cnt does not increment.
- Simultaneous flush and out_ready: the instruction is dropped and out_valid=0.

## Test plan
- Reset, then src_a=SRC_PC, src_b=SRC_4, pc_in=0x100, in_valid=1, out_ready=1 -> next cycle out_valid=1, op_a=0x100, op_b=4. After reset, all outputs were 0.
- rs1=5, rf_rdata1=0x11; fwd entry 1 (rd=5, data=0x22) and entry 0 (rd=5, data=0x33) both valid -> op_a=0x33. With entry 0 invalid -> op_a=0x22. With rs1=0 and both entries targeting x0 -> op_a=0.
- Load-use: rs2=7, src_b=SRC_RS2, entry 0 rd=7 pending for 2 cycles then data 0xABCD -> in_ready=0 for 2 cycles, stall_cnt=2, then op_b=0xABCD captured. Same case with src_b=SRC_IMM and uses_rs2=0 -> no stall.
- Backpressure: out_ready=0 for 3 cycles with a new in_valid -> in_ready=0 and outputs unchanged. Raise out_ready -> new instruction captured on that edge.
- Flush while out_valid=1 and in_valid=1 -> next cycle out_valid=0 and the incoming instruction is not captured. Flush during a hazard -> stall_cnt unchanged.
- Parametrisation: NUM_FWD=4, CNT_W=2. Hold a hazard for 5 cycles -> stall_cnt saturates at 3. Forwarding from entry 3 works when entries 0-2 do not match.

Source files
------------

// File: rtl/id_operand_stage.sv
// ID/EX operand stage: selects ALU operands, forwards rs1/rs2 from in-flight results,
// detects load-use hazards and registers the result under a valid/ready handshake.

package cpu_types_pkg;
    typedef enum logic [1:0] {SRC_RS1 = 2'd0, SRC_PC = 2'd1, SRC_ZERO = 2'd2} src_a_e;
    typedef enum logic [1:0] {SRC_RS2 = 2'd0, SRC_IMM = 2'd1, SRC_4 = 2'd2} src_b_e;
endpackage

module id_operand_stage #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         pc_in,
    input  logic [XLEN-1:0]         imm,
    input  logic [4:0]              rs1_addr,
    input  logic [4:0]              rs2_addr,
    input  logic [XLEN-1:0]         rf_rdata1,
    input  logic [XLEN-1:0]         rf_rdata2,
    input  logic [1:0]              src_a,
    input  logic [1:0]              src_b,
    input  logic                    uses_rs2,
    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [NUM_FWD-1:0]      fwd_pending,
    input  logic [5*NUM_FWD-1:0]    fwd_rd,
    input  logic [XLEN*NUM_FWD-1:0] fwd_data,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         op_a,
    output logic [XLEN-1:0]         op_b,
    output logic [XLEN-1:0]         rs2_val,
    output logic [XLEN-1:0]         pc_out,
    output logic [CNT_W-1:0]        stall_cnt
);
    import cpu_types_pkg::*;

    // Returns {pending, value}; scanning from the oldest entry down lets the youngest match win.
    function automatic logic [XLEN:0] resolve(
        input logic [4:0]              addr,
        input logic [XLEN-1:0]         rf,
        input logic [NUM_FWD-1:0]      v,
        input logic [NUM_FWD-1:0]      p,
        input logic [5*NUM_FWD-1:0]    rd,
        input logic [XLEN*NUM_FWD-1:0] data
    );
        logic            pend;
        logic [XLEN-1:0] val;
        pend = 1'b0;
        val  = rf;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (v[i] && (rd[5*i +: 5] == addr)) begin
                val  = data[XLEN*i +: XLEN];
                pend = p[i];
            end
        end
        if (addr == 5'd0) begin
            val  = '0;
            pend = 1'b0;
        end
        return {pend, val};
    endfunction

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] op_a_q, op_a_d;
    logic [XLEN-1:0] op_b_q, op_b_d;
    logic [XLEN-1:0] rs2_val_q, rs2_val_d;
    logic [XLEN-1:0] pc_out_q, pc_out_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic            rs1_pend, rs2_pend, hazard, capture;
    logic [XLEN-1:0] rs1_val, rs2_fwd, op_a_sel, op_b_sel;

    // NOTE: every signal gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        {rs1_pend, rs1_val} = resolve(rs1_addr, rf_rdata1, fwd_valid, fwd_pending, fwd_rd, fwd_data);
        {rs2_pend, rs2_fwd} = resolve(rs2_addr, rf_rdata2, fwd_valid, fwd_pending, fwd_rd, fwd_data);

        hazard = ((src_a == SRC_RS1) && rs1_pend) ||
                 (((src_b == SRC_RS2) || uses_rs2) && rs2_pend);

        case (src_a)
            SRC_RS1:  op_a_sel = rs1_val;
            SRC_PC:   op_a_sel = pc_in;
            SRC_ZERO: op_a_sel = '0;
            default:  op_a_sel = '0;
        endcase

        case (src_b)
            SRC_RS2: op_b_sel = rs2_fwd;
            SRC_IMM: op_b_sel = imm;
            SRC_4:   op_b_sel = XLEN'(4);
            default: op_b_sel = '0;
        endcase

        in_ready = rst_n && !flush && !hazard && (!out_valid_q || out_ready);
        capture  = in_valid && in_ready;

        out_valid_d = out_valid_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        rs2_val_d   = rs2_val_q;
        pc_out_d    = pc_out_q;
        stall_cnt_d = stall_cnt_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d = 1'b1;
            op_a_d      = op_a_sel;
            op_b_d      = op_b_sel;
            rs2_val_d   = rs2_fwd;
            pc_out_d    = pc_in;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (in_valid && hazard && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: datapath registers are reset as well because they drive visible outputs.
            out_valid_q <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rs2_val_q   <= '0;
            pc_out_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            rs2_val_q   <= rs2_val_d;
            pc_out_q    <= pc_out_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign rs2_val   = rs2_val_q;
    assign pc_out    = pc_out_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: scoreboard on the default instance,
// plus a NUM_FWD=4 / CNT_W=2 instance for saturation and deep forwarding.

module tb_id_operand_stage;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [31:0] pc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // default instance
    logic        in_valid, in_ready, uses_rs2, flush, out_valid, out_ready;
    logic [31:0] pc_in, imm, rf_rdata1, rf_rdata2, op_a, op_b, rs2_val, pc_out;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [1:0]  src_a, src_b, fwd_valid, fwd_pending;
    logic [9:0]  fwd_rd;
    logic [63:0] fwd_data;
    logic [15:0] stall_cnt;

    id_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .imm(imm), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .src_a(src_a), .src_b(src_b),
        .uses_rs2(uses_rs2), .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
        .fwd_rd(fwd_rd), .fwd_data(fwd_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .op_a(op_a), .op_b(op_b), .rs2_val(rs2_val),
        .pc_out(pc_out), .stall_cnt(stall_cnt)
    );

    // parametrised instance
    logic         p_in_valid, p_in_ready, p_uses_rs2, p_flush, p_out_valid, p_out_ready;
    logic [31:0]  p_pc_in, p_imm, p_rf_rdata1, p_rf_rdata2, p_op_a, p_op_b, p_rs2_val, p_pc_out;
    logic [4:0]   p_rs1_addr, p_rs2_addr;
    logic [1:0]   p_src_a, p_src_b, p_stall_cnt;
    logic [3:0]   p_fwd_valid, p_fwd_pending;
    logic [19:0]  p_fwd_rd;
    logic [127:0] p_fwd_data;

    id_operand_stage #(.XLEN(32), .NUM_FWD(4), .CNT_W(2)) dut_p (
        .clk(clk), .rst_n(rst_n), .in_valid(p_in_valid), .in_ready(p_in_ready),
        .pc_in(p_pc_in), .imm(p_imm), .rs1_addr(p_rs1_addr), .rs2_addr(p_rs2_addr),
        .rf_rdata1(p_rf_rdata1), .rf_rdata2(p_rf_rdata2), .src_a(p_src_a), .src_b(p_src_b),
        .uses_rs2(p_uses_rs2), .fwd_valid(p_fwd_valid), .fwd_pending(p_fwd_pending),
        .fwd_rd(p_fwd_rd), .fwd_data(p_fwd_data), .flush(p_flush), .out_valid(p_out_valid),
        .out_ready(p_out_ready), .op_a(p_op_a), .op_b(p_op_b), .rs2_val(p_rs2_val),
        .pc_out(p_pc_out), .stall_cnt(p_stall_cnt)
    );

    function automatic void push(input logic [31:0] a, b, r, pc);
        exp_t e;
        e.a = a; e.b = b; e.r = r; e.pc = pc;
        q.push_back(e);
    endfunction

    // Scoreboard: compare the held instruction on the cycle EX takes it.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got pc_out=%h, required no output", pc_out);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (op_a !== e.a || op_b !== e.b || rs2_val !== e.r || pc_out !== e.pc) begin
                    errors++;
                    $display("FAIL sb_data: got a=%h b=%h r=%h pc=%h, required a=%h b=%h r=%h pc=%h",
                             op_a, op_b, rs2_val, pc_out, e.a, e.b, e.r, e.pc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        in_valid = 0; flush = 0; out_ready = 1; uses_rs2 = 0;
        src_a = 2'd1; src_b = 2'd1; pc_in = 0; imm = 0;
        rs1_addr = 0; rs2_addr = 0; rf_rdata1 = 0; rf_rdata2 = 0;
        fwd_valid = 0; fwd_pending = 0; fwd_rd = 0; fwd_data = 0;
        p_in_valid = 0; p_flush = 0; p_out_ready = 1; p_uses_rs2 = 0;
        p_src_a = 2'd1; p_src_b = 2'd1; p_pc_in = 0; p_imm = 0;
        p_rs1_addr = 0; p_rs2_addr = 0; p_rf_rdata1 = 0; p_rf_rdata2 = 0;
        p_fwd_valid = 0; p_fwd_pending = 0; p_fwd_rd = 0; p_fwd_data = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        set_idle();
        in_valid = 1; pc_in = 32'h0dead000; src_b = 2'd2;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 0);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_op_a", op_a, 0);
        chk("reset_op_b", op_b, 0);
        chk("reset_rs2_val", rs2_val, 0);
        chk("reset_pc_out", pc_out, 0);
        chk("reset_stall_cnt", 32'(stall_cnt), 0);
        chk("reset_p_stall_cnt", 32'(p_stall_cnt), 0);
        tick();
        rst_n = 1; in_valid = 0;
        tick();
    endtask

    task automatic test_basic();
        src_a = 2'd1; src_b = 2'd2; pc_in = 32'h100; in_valid = 1;
        @(negedge clk);
        chk("basic_in_ready", 32'(in_ready), 1);
        push(32'h100, 32'd4, 32'h0, 32'h100);
        tick();
        in_valid = 0;
        @(negedge clk);
        chk("basic_out_valid", 32'(out_valid), 1);
        tick();
        @(negedge clk);
        chk("basic_drained", 32'(out_valid), 0);
        tick();
    endtask

    task automatic test_forward();
        src_a = 2'd0; src_b = 2'd1; imm = 32'h10; pc_in = 32'h400; in_valid = 1;
        rs1_addr = 5; rs2_addr = 5; rf_rdata1 = 32'h11; rf_rdata2 = 32'h44;
        fwd_rd = {5'd5, 5'd5}; fwd_data = {32'h22, 32'h33}; fwd_valid = 2'b11;
        push(32'h33, 32'h10, 32'h33, 32'h400);
        tick();
        fwd_valid = 2'b10; pc_in = 32'h404;
        push(32'h22, 32'h10, 32'h22, 32'h404);
        tick();
        rs1_addr = 0; rs2_addr = 0; fwd_rd = 10'd0; fwd_valid = 2'b11;
        rf_rdata1 = 32'h55; rf_rdata2 = 32'h66; pc_in = 32'h408;
        push(32'h0, 32'h10, 32'h0, 32'h408);
        tick();
        rs1_addr = 6; rs2_addr = 9; fwd_rd = {5'd5, 5'd5}; rf_rdata1 = 32'h11; pc_in = 32'h40c;
        push(32'h11, 32'h10, 32'h66, 32'h40c);
        tick();
        in_valid = 0; fwd_valid = 0;
        tick();
    endtask

    task automatic test_load_use();
        src_a = 2'd2; src_b = 2'd0; uses_rs2 = 0; pc_in = 32'h500; rs1_addr = 0; rs2_addr = 7;
        fwd_rd = {5'd0, 5'd7}; fwd_valid = 2'b01; fwd_pending = 2'b01;
        fwd_data = {32'h0, 32'hdead}; in_valid = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("lu_in_ready_stall", 32'(in_ready), 0);
            tick();
        end
        fwd_pending = 2'b00; fwd_data = {32'h0, 32'habcd};
        @(negedge clk);
        chk("lu_in_ready_release", 32'(in_ready), 1);
        chk("lu_stall_cnt", 32'(stall_cnt), 2);
        push(32'h0, 32'habcd, 32'habcd, 32'h500);
        tick();
        // not needed as operand B: pending value passes through as rs2_val without stalling
        src_b = 2'd1; imm = 32'h20; fwd_pending = 2'b01; fwd_data = {32'h0, 32'hdead}; pc_in = 32'h504;
        @(negedge clk);
        chk("lu_imm_no_stall", 32'(in_ready), 1);
        push(32'h0, 32'h20, 32'hdead, 32'h504);
        tick();
        // pending older entry shadowed by a ready younger match
        src_b = 2'd0; fwd_rd = {5'd7, 5'd7}; fwd_valid = 2'b11; fwd_pending = 2'b10;
        fwd_data = {32'hbad, 32'h77}; pc_in = 32'h508;
        @(negedge clk);
        chk("lu_shadow_no_stall", 32'(in_ready), 1);
        push(32'h0, 32'h77, 32'h77, 32'h508);
        tick();
        in_valid = 0; fwd_valid = 0; fwd_pending = 0;
        @(negedge clk);
        chk("lu_stall_cnt_after", 32'(stall_cnt), 2);
        tick();
    endtask

    task automatic test_backpressure();
        src_a = 2'd1; src_b = 2'd2; rs2_addr = 0; pc_in = 32'h200; in_valid = 1; out_ready = 1;
        push(32'h200, 32'd4, 32'h0, 32'h200);
        tick();
        out_ready = 0; pc_in = 32'h300;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_hold_pc", pc_out, 32'h200);
            chk("bp_hold_valid", 32'(out_valid), 1);
            tick();
        end
        out_ready = 1;
        push(32'h300, 32'd4, 32'h0, 32'h300);
        @(negedge clk);
        chk("bp_release_ready", 32'(in_ready), 1);
        tick();
        in_valid = 0;
        tick();
        tick();
    endtask

    task automatic test_flush();
        src_a = 2'd1; src_b = 2'd2; pc_in = 32'h600; in_valid = 1; out_ready = 1;
        tick();
        out_ready = 0; flush = 1; pc_in = 32'h700;
        @(negedge clk);
        chk("fl_held_pc", pc_out, 32'h600);
        chk("fl_in_ready", 32'(in_ready), 0);
        tick();
        flush = 0; in_valid = 0; out_ready = 1;
        @(negedge clk);
        chk("fl_out_valid", 32'(out_valid), 0);
        chk("fl_no_capture", pc_out, 32'h600);
        tick();
        // flush during a hazard: no stall counted, nothing captured
        src_a = 2'd0; rs1_addr = 3; fwd_rd = {5'd0, 5'd3}; fwd_valid = 2'b01; fwd_pending = 2'b01;
        in_valid = 1; flush = 1;
        tick();
        flush = 0; in_valid = 0; fwd_valid = 0; fwd_pending = 0;
        @(negedge clk);
        chk("fl_hazard_stall_cnt", 32'(stall_cnt), 2);
        chk("fl_hazard_out_valid", 32'(out_valid), 0);
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] r2;
        src_a = 2'd1; src_b = 2'd1; out_ready = 1; fwd_valid = 0; in_valid = 1;
        for (int i = 0; i < 8; i++) begin
            pc_in = 32'h1000 + 32'(4 * i);
            imm = $urandom;
            rs2_addr = 5'(i);
            rf_rdata2 = $urandom;
            r2 = (i == 0) ? 32'h0 : rf_rdata2;
            @(negedge clk);
            chk("b2b_in_ready", 32'(in_ready), 1);
            push(pc_in, imm, r2, pc_in);
            tick();
        end
        in_valid = 0;
        tick();
        tick();
    endtask

    task automatic test_param();
        p_src_a = 2'd0; p_src_b = 2'd1; p_rs1_addr = 3;
        p_fwd_rd = {5'd0, 5'd0, 5'd3, 5'd0}; p_fwd_valid = 4'b0010; p_fwd_pending = 4'b0010;
        p_in_valid = 1;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                @(negedge clk);
                chk("p_stall_cnt_2", 32'(p_stall_cnt), 2);
            end
            tick();
        end
        @(negedge clk);
        chk("p_stall_sat", 32'(p_stall_cnt), 3);
        chk("p_in_ready_stall", 32'(p_in_ready), 0);
        p_in_valid = 0; p_fwd_pending = 0;
        tick();
        p_rs1_addr = 9; p_src_b = 2'd2; p_pc_in = 32'h800; p_rf_rdata1 = 32'h1;
        p_fwd_rd = {5'd9, 5'd4, 5'd2, 5'd1}; p_fwd_valid = 4'b1111;
        p_fwd_data = {32'h9999, 32'h4444, 32'h2222, 32'h1111};
        p_in_valid = 1;
        tick();
        p_src_a = 2'd3; p_src_b = 2'd3; p_pc_in = 32'h804;
        @(negedge clk);
        chk("p_fwd3_valid", 32'(p_out_valid), 1);
        chk("p_fwd3_op_a", p_op_a, 32'h9999);
        chk("p_fwd3_op_b", p_op_b, 32'd4);
        tick();
        p_in_valid = 0;
        @(negedge clk);
        chk("p_rsvd_op_a", p_op_a, 32'h0);
        chk("p_rsvd_op_b", p_op_b, 32'h0);
        chk("p_rsvd_pc", p_pc_out, 32'h804);
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_forward();
        test_load_use();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_param();
        tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending entries, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

endmodule
